// File: rtl/tetron_cell_prober_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : tetron_cell_prober_pkg                                        |
// | Purpose   : Shared types and constants for the tetron cell prober:       |
// |             operation codes, FSM state encoding, board defaults and a    |
// |             sign-extension helper for 5-bit shaper offsets.              |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package tetron_cell_prober_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;

  // Signed coordinate width: 5-bit anchor plus 5-bit signed offset spans
  // -16..46, which fits comfortably in 7 signed bits.
  localparam int COORD_W = 7;

  localparam logic OP_CHECK = 1'b0;
  localparam logic OP_LOCK  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  function automatic logic signed [COORD_W-1:0] sext5(input logic [4:0] v);
    return {{(COORD_W-5){v[4]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tetron_cell_addr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tetron_cell_addr                                             |
// | Purpose   : Combinational resolution of one tetron block: anchor plus    |
// |             signed offset -> linear playfield address and out-of-bounds. |
// | Ports     : vpos/hpos   in  5       anchor row/column (unsigned)         |
// |             voffset     in  5       row offset (two's complement)        |
// |             hoffset     in  5       column offset (two's complement)     |
// |             addr        out ADDR_W  row*BOARD_W + col (0 when oob)       |
// |             oob         out 1       cell lies outside the board          |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tetron_cell_addr
  import tetron_cell_prober_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int ADDR_W  = 8
) (
  input  logic [4:0]        vpos,
  input  logic [4:0]        hpos,
  input  logic [4:0]        voffset,
  input  logic [4:0]        hoffset,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);

  localparam logic signed [COORD_W-1:0] ROW_LIM = COORD_W'(BOARD_H);
  localparam logic signed [COORD_W-1:0] COL_LIM = COORD_W'(BOARD_W);
  localparam logic [ADDR_W-1:0]         W_A     = ADDR_W'(BOARD_W);

  logic signed [COORD_W-1:0] row;
  logic signed [COORD_W-1:0] col;
  logic [ADDR_W-1:0]         row_a;
  logic [ADDR_W-1:0]         col_a;

  assign row = $signed({2'b00, vpos}) + sext5(voffset);
  assign col = $signed({2'b00, hpos}) + sext5(hoffset);

  // Sign bit catches negative coordinates; signed compare catches overflow.
  assign oob = row[COORD_W-1] || (row >= ROW_LIM) ||
               col[COORD_W-1] || (col >= COL_LIM);

  // Only the in-bounds case matters, where row/col are small non-negatives.
  assign row_a = ADDR_W'(row[COORD_W-2:0]);
  assign col_a = ADDR_W'(col[COORD_W-2:0]);
  assign addr  = oob ? '0 : (row_a * W_A + col_a);

endmodule
`default_nettype wire

// File: rtl/tetron_cell_prober.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tetron_cell_prober                                           |
// | Purpose   : Resolves a shaper's anchor + four offsets to playfield cells |
// |             and either reads them for collision (CHECK) or writes the    |
// |             piece colour into them (LOCK).                               |
// | Ports     : clk, rst_n                 clock, async active-low reset     |
// |             req_valid/req_ready        request handshake                 |
// |             req_op                     0 = CHECK, 1 = LOCK               |
// |             req_vpos/req_hpos          anchor row/column                 |
// |             req_blkN_voffset/hoffset   signed offsets, N = 1..4          |
// |             req_color                  colour written on LOCK            |
// |             fld_addr/fld_rd_en/fld_rdata/fld_we/fld_wdata  playfield RAM |
// |             resp_valid/resp_ready      response handshake                |
// |             resp_collide               collision / out-of-bounds result  |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tetron_cell_prober
  import tetron_cell_prober_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int ADDR_W  = 8,
  parameter int COLOR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_op,
  input  logic [4:0]         req_vpos,
  input  logic [4:0]         req_hpos,
  input  logic [4:0]         req_blk1_voffset,
  input  logic [4:0]         req_blk1_hoffset,
  input  logic [4:0]         req_blk2_voffset,
  input  logic [4:0]         req_blk2_hoffset,
  input  logic [4:0]         req_blk3_voffset,
  input  logic [4:0]         req_blk3_hoffset,
  input  logic [4:0]         req_blk4_voffset,
  input  logic [4:0]         req_blk4_hoffset,
  input  logic [COLOR_W-1:0] req_color,
  output logic [ADDR_W-1:0]  fld_addr,
  output logic               fld_rd_en,
  input  logic [COLOR_W-1:0] fld_rdata,
  output logic               fld_we,
  output logic [COLOR_W-1:0] fld_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_collide
);

  state_t                  state;
  state_t                  state_nx;
  logic                    accept;
  logic                    resp_done;
  logic                    issue_strobe;
  logic [1:0]              idx;

  logic                    op_q;
  logic [4:0]              vpos_q;
  logic [4:0]              hpos_q;
  logic [3:0][4:0]         voff_q;
  logic [3:0][4:0]         hoff_q;
  logic [3:0][4:0]         voff_in;
  logic [3:0][4:0]         hoff_in;
  logic [COLOR_W-1:0]      color_q;

  logic [3:0][ADDR_W-1:0]  addr_w;
  logic [3:0][ADDR_W-1:0]  addr_q;
  logic [3:0]              oob_w;
  logic [3:0]              oob_q;

  logic                    collide_q;
  logic                    rd_pend;

  assign voff_in = {req_blk4_voffset, req_blk3_voffset, req_blk2_voffset, req_blk1_voffset};
  assign hoff_in = {req_blk4_hoffset, req_blk3_hoffset, req_blk2_hoffset, req_blk1_hoffset};

  // Address units work from the captured request so later input changes
  // cannot disturb an operation in flight.
  for (genvar i = 0; i < 4; i++) begin : g_cell
    tetron_cell_addr #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H),
      .ADDR_W  (ADDR_W)
    ) u_addr (
      .vpos    (vpos_q),
      .hpos    (hpos_q),
      .voffset (voff_q[i]),
      .hoffset (hoff_q[i]),
      .addr    (addr_w[i]),
      .oob     (oob_w[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    accept       = 1'b0;
    resp_done    = 1'b0;
    issue_strobe = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = ST_CALC;
        end
      end
      ST_CALC: begin
        state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Out-of-bounds cells still spend their slot to keep latency fixed.
        issue_strobe = !oob_q[idx];
        if (idx == 2'd3) begin
          state_nx = (op_q == OP_LOCK) ? ST_RESP : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (resp_valid && resp_ready) begin
          resp_done = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 2'd0;
      op_q       <= OP_CHECK;
      vpos_q     <= '0;
      hpos_q     <= '0;
      voff_q     <= '0;
      hoff_q     <= '0;
      color_q    <= '0;
      addr_q     <= '0;
      oob_q      <= '0;
      collide_q  <= 1'b0;
      rd_pend    <= 1'b0;
      fld_rd_en  <= 1'b0;
      fld_we     <= 1'b0;
      fld_addr   <= '0;
      fld_wdata  <= '0;
      resp_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        vpos_q  <= req_vpos;
        hpos_q  <= req_hpos;
        voff_q  <= voff_in;
        hoff_q  <= hoff_in;
        color_q <= req_color;
      end

      if (state == ST_CALC) begin
        addr_q <= addr_w;
        oob_q  <= oob_w;
        idx    <= 2'd0;
      end else if (state == ST_ISSUE) begin
        idx <= idx + 2'd1;
      end

      // Strobes are registered, so cell i appears on the RAM port the
      // cycle after the FSM visits slot i.
      fld_rd_en <= issue_strobe && (op_q == OP_CHECK);
      fld_we    <= issue_strobe && (op_q == OP_LOCK);
      fld_addr  <= issue_strobe ? addr_q[idx] : '0;
      fld_wdata <= (issue_strobe && (op_q == OP_LOCK)) ? color_q : '0;

      // The RAM returns data one cycle after the strobe; rd_pend marks the
      // cycle in which fld_rdata belongs to one of our reads.
      rd_pend <= fld_rd_en;

      if (accept) begin
        collide_q <= 1'b0;
      end else if (state == ST_CALC) begin
        collide_q <= |oob_w;
      end else if (rd_pend && (fld_rdata != '0)) begin
        collide_q <= 1'b1;
      end

      resp_valid <= (state == ST_RESP) && !resp_done;
    end
  end

  assign resp_collide = collide_q;

endmodule
`default_nettype wire

// File: tb/tb_tetron_cell_prober.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_tetron_cell_prober                                        |
// | Purpose   : Self-checking bench: behavioural RAM, reference cell model,  |
// |             directed scenarios and randomized back-to-back requests.     |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_tetron_cell_prober;

  localparam int BW   = 10;
  localparam int BH   = 20;
  localparam int AW   = 8;
  localparam int CW   = 3;
  localparam int MAXW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_op = 1'b0;
  logic [4:0]    req_vpos = '0, req_hpos = '0;
  logic [4:0]    req_blk1_voffset = '0, req_blk1_hoffset = '0;
  logic [4:0]    req_blk2_voffset = '0, req_blk2_hoffset = '0;
  logic [4:0]    req_blk3_voffset = '0, req_blk3_hoffset = '0;
  logic [4:0]    req_blk4_voffset = '0, req_blk4_hoffset = '0;
  logic [CW-1:0] req_color = '0;
  logic [AW-1:0] fld_addr;
  logic          fld_rd_en;
  logic [CW-1:0] fld_rdata = '0;
  logic          fld_we;
  logic [CW-1:0] fld_wdata;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_collide;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tetron_cell_prober #(
    .BOARD_W (BW),
    .BOARD_H (BH),
    .ADDR_W  (AW),
    .COLOR_W (CW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_vpos         (req_vpos),
    .req_hpos         (req_hpos),
    .req_blk1_voffset (req_blk1_voffset),
    .req_blk1_hoffset (req_blk1_hoffset),
    .req_blk2_voffset (req_blk2_voffset),
    .req_blk2_hoffset (req_blk2_hoffset),
    .req_blk3_voffset (req_blk3_voffset),
    .req_blk3_hoffset (req_blk3_hoffset),
    .req_blk4_voffset (req_blk4_voffset),
    .req_blk4_hoffset (req_blk4_hoffset),
    .req_color        (req_color),
    .fld_addr         (fld_addr),
    .fld_rd_en        (fld_rd_en),
    .fld_rdata        (fld_rdata),
    .fld_we           (fld_we),
    .fld_wdata        (fld_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_collide     (resp_collide)
  );

  // Playfield RAM: registered read, data valid the cycle after the strobe.
  logic [CW-1:0] mem [256];
  logic          clr = 1'b0;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [CW-1:0] poke_data = '0;
  int            wr_log[$];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (poke_en) mem[poke_addr] <= poke_data;
      if (fld_we) begin
        mem[fld_addr] <= fld_wdata;
        wr_log.push_back(int'(fld_addr));
      end
    end
    if (fld_rd_en) fld_rdata <= mem[fld_addr];
  end

  // Reference model state.
  int ref_board[256];
  int cur_vo[4], cur_ho[4];
  int exp_addr[4];
  bit exp_oob[4];

  logic          log_rd[16], log_we[16];
  logic [AW-1:0] log_addr[16];
  logic [CW-1:0] log_wd[16];

  task automatic clear_board();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_board[i] = 0;
  endtask

  task automatic poke(input int a, input int d);
    poke_en = 1'b1; poke_addr = AW'(a); poke_data = CW'(d);
    @(posedge clk); #1;
    poke_en = 1'b0;
    ref_board[a] = d;
  endtask

  task automatic set_offsets(input int v0, h0, v1, h1, v2, h2, v3, h3);
    cur_vo[0] = v0; cur_ho[0] = h0; cur_vo[1] = v1; cur_ho[1] = h1;
    cur_vo[2] = v2; cur_ho[2] = h2; cur_vo[3] = v3; cur_ho[3] = h3;
  endtask

  // Cell placement straight from board geometry.
  task automatic model_cells(input int vp, input int hp);
    for (int i = 0; i < 4; i++) begin
      int r, c;
      r = vp + cur_vo[i];
      c = hp + cur_ho[i];
      exp_oob[i]  = (r < 0) || (r >= BH) || (c < 0) || (c >= BW);
      exp_addr[i] = exp_oob[i] ? 0 : r * BW + c;
    end
  endtask

  function automatic bit model_collide(input bit op);
    bit hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (exp_oob[i]) hit = 1'b1;
      else if (op == 1'b0 && ref_board[exp_addr[i]] != 0) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic drive_req(input bit op, input int vp, input int hp, input int col);
    req_op = op; req_vpos = 5'(vp); req_hpos = 5'(hp); req_color = CW'(col);
    req_blk1_voffset = 5'(cur_vo[0]); req_blk1_hoffset = 5'(cur_ho[0]);
    req_blk2_voffset = 5'(cur_vo[1]); req_blk2_hoffset = 5'(cur_ho[1]);
    req_blk3_voffset = 5'(cur_vo[2]); req_blk3_hoffset = 5'(cur_ho[2]);
    req_blk4_voffset = 5'(cur_vo[3]); req_blk4_hoffset = 5'(cur_ho[3]);
    req_valid = 1'b1;
  endtask

  task automatic scramble_req();
    req_valid = 1'b0;
    req_op = 1'($urandom); req_vpos = 5'($urandom); req_hpos = 5'($urandom);
    req_color = CW'($urandom);
    req_blk1_voffset = 5'($urandom); req_blk1_hoffset = 5'($urandom);
    req_blk2_voffset = 5'($urandom); req_blk2_hoffset = 5'($urandom);
    req_blk3_voffset = 5'($urandom); req_blk3_hoffset = 5'($urandom);
    req_blk4_voffset = 5'($urandom); req_blk4_hoffset = 5'($urandom);
  endtask

  // Issues one request from an idle point (#1 after an edge), records the RAM
  // port each cycle, and returns the cycle offset at which resp_valid rose
  // (-1 if it never did). The response is left un-acknowledged.
  task automatic run_req(input bit op, input int vp, input int hp, input int col,
                         output int lat);
    drive_req(op, vp, hp, col);
    @(posedge clk); #1;
    scramble_req();
    lat = -1;
    for (int k = 1; k <= MAXW; k++) begin
      @(posedge clk); #1;
      log_rd[k] = fld_rd_en; log_we[k] = fld_we;
      log_addr[k] = fld_addr; log_wd[k] = fld_wdata;
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic ack_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_collide !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: req_ready=%0b resp_valid=%0b collide=%0b expected 1 0 0",
               req_ready, resp_valid, resp_collide);
    end
    checks++;
    if (fld_rd_en !== 1'b0 || fld_we !== 1'b0 || fld_addr !== '0 || fld_wdata !== '0) begin
      errors++;
      $display("FAIL reset_fld: rd=%0b we=%0b addr=%0d wdata=%0d expected all 0",
               fld_rd_en, fld_we, fld_addr, fld_wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || fld_rd_en !== 1'b0 || fld_we !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: req_ready=%0b rd=%0b we=%0b expected 1 0 0",
               req_ready, fld_rd_en, fld_we);
    end
  endtask

  // Scenarios: empty CHECK, occupied CHECK, oob CHECK, LOCK at the bottom.
  task automatic test_directed();
    bit tbl_op[4]      = '{1'b0, 1'b0, 1'b0, 1'b1};
    int tbl_vp[4]      = '{5, 5, 5, 18};
    int tbl_hp[4]      = '{4, 4, 0, 4};
    int tbl_poke[4]    = '{-1, 53, -1, -1};
    bit tbl_coll[4]    = '{1'b0, 1'b1, 1'b1, 1'b0};
    int tbl_lat[4]     = '{7, 7, 7, 6};
    for (int s = 0; s < 4; s++) begin
      int lat;
      bit op;
      op = tbl_op[s];
      clear_board();
      if (tbl_poke[s] >= 0) poke(tbl_poke[s], 2);
      set_offsets(0, 0, -1, -1, 0, -1, 1, 0);
      model_cells(tbl_vp[s], tbl_hp[s]);
      checks++;
      if (model_collide(op) != tbl_coll[s]) begin
        errors++;
        $display("FAIL dir%0d model_sanity: got %0b expected %0b", s, model_collide(op), tbl_coll[s]);
      end
      run_req(op, tbl_vp[s], tbl_hp[s], 5, lat);
      checks++;
      if (lat !== tbl_lat[s]) begin
        errors++;
        $display("FAIL dir%0d latency: got T+%0d expected T+%0d", s, lat, tbl_lat[s]);
      end
      for (int k = 1; k <= lat; k++) begin
        bit e_rd, e_we;
        int e_addr;
        int ci;
        ci = k - 2;
        e_rd = 1'b0; e_we = 1'b0; e_addr = 0;
        if (ci >= 0 && ci < 4 && !exp_oob[ci]) begin
          e_rd = (op == 1'b0); e_we = (op == 1'b1); e_addr = exp_addr[ci];
        end
        checks++;
        if (log_rd[k] !== e_rd || log_we[k] !== e_we ||
            ((e_rd || e_we) && int'(log_addr[k]) != e_addr) ||
            (ci >= 0 && ci < 4 && exp_oob[ci] && log_addr[k] !== '0) ||
            (e_we && int'(log_wd[k]) != 5)) begin
          errors++;
          $display("FAIL dir%0d strobe T+%0d: rd=%0b we=%0b addr=%0d wd=%0d expected rd=%0b we=%0b addr=%0d wd=5",
                   s, k, log_rd[k], log_we[k], log_addr[k], log_wd[k], e_rd, e_we, e_addr);
        end
      end
      checks++;
      if (resp_collide !== tbl_coll[s]) begin
        errors++;
        $display("FAIL dir%0d collide: got %0b expected %0b", s, resp_collide, tbl_coll[s]);
      end
      ack_resp();
      if (op == 1'b1) begin
        checks++;
        if (mem[184] !== 3'd5 || mem[173] !== 3'd5 || mem[183] !== 3'd5 || mem[194] !== 3'd5) begin
          errors++;
          $display("FAIL dir%0d lock_cells: %0d %0d %0d %0d expected 5 5 5 5",
                   s, mem[184], mem[173], mem[183], mem[194]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    clear_board();
    poke(53, 2);
    set_offsets(0, 0, -1, -1, 0, -1, 1, 0);
    model_cells(5, 4);
    run_req(1'b0, 5, 4, 1, lat);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL bp_latency: got T+%0d expected T+7", lat);
    end
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_collide !== model_collide(1'b0) || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: resp_valid=%0b collide=%0b req_ready=%0b expected 1 %0b 0",
                 h, resp_valid, resp_collide, req_ready, model_collide(1'b0));
      end
      req_valid = (h != 1);
      req_op = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    ack_resp();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_ack: resp_valid=%0b req_ready=%0b expected 0 1", resp_valid, req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (fld_rd_en !== 1'b0 || fld_we !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_idle%0d: rd=%0b we=%0b req_ready=%0b resp_valid=%0b expected 0 0 1 0",
                 c, fld_rd_en, fld_we, req_ready, resp_valid);
      end
    end
  endtask

  task automatic test_reset_abort();
    int stray;
    clear_board();
    wr_log.delete();
    set_offsets(0, 0, -1, -1, 0, -1, 1, 0);
    drive_req(1'b1, 18, 4, 5);
    @(posedge clk); #1;
    scramble_req();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fld_we !== 1'b0 || fld_rd_en !== 1'b0 || fld_addr !== '0 || fld_wdata !== '0 ||
        resp_valid !== 1'b0 || resp_collide !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_outputs: we=%0b rd=%0b addr=%0d wd=%0d rv=%0b coll=%0b rr=%0b expected 0 0 0 0 0 0 1",
               fld_we, fld_rd_en, fld_addr, fld_wdata, resp_valid, resp_collide, req_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (fld_we !== 1'b0 || fld_rd_en !== 1'b0 || resp_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_no_strobes: %0d active cycles expected 0", stray);
    end
    checks++;
    if (wr_log.size() != 1 || wr_log[0] != 184) begin
      errors++;
      $display("FAIL abort_writes: %0d writes first=%0d expected 1 write at 184",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : -1);
    end
  endtask

  task automatic test_random_back_to_back();
    int bad_cells;
    clear_board();
    for (int i = 0; i < 30; i++) poke($urandom_range(0, BW * BH - 1), $urandom_range(1, 7));
    for (int it = 0; it < 40; it++) begin
      bit op, e_coll;
      int vp, hp, col, lat, e_lat, hold;
      op = 1'($urandom_range(0, 1));
      vp = $urandom_range(0, 21);
      hp = $urandom_range(0, 11);
      col = $urandom_range(1, 7);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          cur_vo[i] = int'($urandom_range(0, 31)) - 16;
          cur_ho[i] = int'($urandom_range(0, 31)) - 16;
        end else begin
          cur_vo[i] = int'($urandom_range(0, 4)) - 2;
          cur_ho[i] = int'($urandom_range(0, 4)) - 2;
        end
      end
      model_cells(vp, hp);
      e_coll = model_collide(op);
      e_lat = op ? 6 : 7;
      run_req(op, vp, hp, col, lat);
      checks++;
      if (lat !== e_lat) begin
        errors++;
        $display("FAIL rnd%0d latency: got T+%0d expected T+%0d", it, lat, e_lat);
      end
      for (int k = 1; k <= lat; k++) begin
        bit e_rd, e_we;
        int e_addr;
        int ci;
        ci = k - 2;
        e_rd = 1'b0; e_we = 1'b0; e_addr = 0;
        if (ci >= 0 && ci < 4 && !exp_oob[ci]) begin
          e_rd = !op; e_we = op; e_addr = exp_addr[ci];
        end
        checks++;
        if (log_rd[k] !== e_rd || log_we[k] !== e_we ||
            ((e_rd || e_we) && int'(log_addr[k]) != e_addr) ||
            (ci >= 0 && ci < 4 && exp_oob[ci] && log_addr[k] !== '0) ||
            (e_we && int'(log_wd[k]) != col)) begin
          errors++;
          $display("FAIL rnd%0d strobe T+%0d: rd=%0b we=%0b addr=%0d wd=%0d expected rd=%0b we=%0b addr=%0d wd=%0d",
                   it, k, log_rd[k], log_we[k], log_addr[k], log_wd[k], e_rd, e_we, e_addr, col);
        end
      end
      checks++;
      if (resp_collide !== e_coll) begin
        errors++;
        $display("FAIL rnd%0d collide: got %0b expected %0b", it, resp_collide, e_coll);
      end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_collide !== e_coll) begin
          errors++;
          $display("FAIL rnd%0d hold%0d: resp_valid=%0b collide=%0b expected 1 %0b",
                   it, h, resp_valid, resp_collide, e_coll);
        end
      end
      ack_resp();
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d ready_after_ack: got %0b expected 1", it, req_ready);
      end
      if (op) begin
        for (int i = 0; i < 4; i++) if (!exp_oob[i]) ref_board[exp_addr[i]] = col;
      end
    end
    bad_cells = 0;
    for (int a = 0; a < BW * BH; a++) if (int'(mem[a]) != ref_board[a]) bad_cells++;
    checks++;
    if (bad_cells != 0) begin
      errors++;
      $display("FAIL rnd_board: %0d cells differ expected 0", bad_cells);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
